// File: rtl/rr_packet_arbiter_4_to_1.sv
// ---------------------------------------------------------------------------
// rr_packet_arbiter_4_to_1
//
// Purpose:
//   Round-robin arbiter that shares one output channel between four
//   valid/ready requesters. A grant is held for a whole packet and is
//   released only when a beat with last=1 is accepted. The granted index
//   drives the select of a 4:1 data mux feeding a single-entry registered
//   output stage.
//
// Ports:
//   clk        in   1   system clock
//   rst        in   1   asynchronous reset, active-high
//   in_valid   in   4   per-requester beat valid (bit i = requester i)
//   in_last    in   4   per-requester last-beat-of-packet flag
//   in_data_a  in   W   requester 0 data
//   in_data_b  in   W   requester 1 data
//   in_data_c  in   W   requester 2 data
//   in_data_d  in   W   requester 3 data
//   in_ready   out  4   per-requester ready, one-hot or zero
//   out_valid  out  1   output register holds a beat
//   out_last   out  1   last flag of the held beat
//   out_data   out  W   held beat data
//   out_ready  in   1   downstream accepts the held beat
//   grant_sel  out  2   current grant index (mux select)
//   busy       out  1   high while a packet grant is locked
// ---------------------------------------------------------------------------

// 4:1 data selector used for the requester datapath.
module mux_4_to_1 #(
    parameter int W = 1
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);
    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

module rr_packet_arbiter_4_to_1 #(
    parameter int  INPUT_BIT_LENGTH = 1,
    // Widths below 1 collapse to a single data bit.
    localparam int W = (INPUT_BIT_LENGTH < 1) ? 1 : INPUT_BIT_LENGTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    input  logic [3:0]   in_last,
    input  logic [W-1:0] in_data_a,
    input  logic [W-1:0] in_data_b,
    input  logic [W-1:0] in_data_c,
    input  logic [W-1:0] in_data_d,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    output logic         out_last,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   grant_sel,
    output logic         busy
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t         r_state;
    logic [1:0]     r_ptr;
    logic [1:0]     r_grant_sel;
    logic           r_out_valid;
    logic           r_out_last;
    logic [W-1:0]   r_out_data;

    logic [1:0]     w_cand [4];
    logic [3:0]     w_hit;
    logic [1:0]     w_winner;
    logic [3:0]     w_grant_onehot;
    logic           w_space;
    logic           w_sel_valid;
    logic           w_sel_last;
    logic           w_xfer;
    logic [W-1:0]   w_mux_data;

    // Candidate k is the requester k+1 places after the last finisher, so
    // candidate 3 wraps back onto the last finisher itself (lowest priority).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rr
            assign w_cand[gi]         = r_ptr + 2'(gi + 1);
            assign w_hit[gi]          = in_valid[w_cand[gi]];
            assign w_grant_onehot[gi] = (r_grant_sel == 2'(gi));
        end
    endgenerate

    // Lowest-numbered candidate with a valid request wins.
    always_comb begin
        w_winner = w_cand[3];
        for (int k = 3; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_winner = w_cand[k];
            end
        end
    end

    mux_4_to_1 #(.W(W)) u_mux (
        .sel (r_grant_sel),
        .d0  (in_data_a),
        .d1  (in_data_b),
        .d2  (in_data_c),
        .d3  (in_data_d),
        .y   (w_mux_data)
    );

    // The output slot can take a beat when empty or being drained this
    // cycle; this keeps out_ready -> in_ready combinational while in_valid
    // never reaches in_ready.
    assign w_space     = !r_out_valid || out_ready;
    assign w_sel_valid = in_valid[r_grant_sel];
    assign w_sel_last  = in_last[r_grant_sel];
    assign w_xfer      = (r_state == S_LOCKED) && w_space && w_sel_valid;

    assign in_ready  = ((r_state == S_LOCKED) && w_space) ? w_grant_onehot : 4'b0000;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;
    assign grant_sel = r_grant_sel;
    assign busy      = (r_state == S_LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd3;
            r_grant_sel <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|in_valid) begin
                        r_grant_sel <= w_winner;
                        r_state     <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    // Grant releases only on an accepted last beat.
                    if (w_xfer && w_sel_last) begin
                        r_ptr   <= r_grant_sel;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux_data;
                r_out_last  <= w_sel_last;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_packet_arbiter_4_to_1.sv
`timescale 1ns/1ps

module tb_rr_packet_arbiter_4_to_1;

    typedef struct {
        int         gap;
        logic       last;
        logic [7:0] data;
    } beat_t;

    logic       clk;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] in_last;
    logic [7:0] in_data_a, in_data_b, in_data_c, in_data_d;
    logic [3:0] in_ready;
    logic       out_valid, out_last, out_ready;
    logic [7:0] out_data;
    logic [1:0] grant_sel;
    logic       busy;

    logic [3:0] d1_in_ready;
    logic       d1_out_valid, d1_out_last, d1_busy;
    logic [0:0] d1_out_data;
    logic [1:0] d1_grant_sel;

    beat_t      rq [4][$];
    int         cnt [4];
    logic [8:0] exp_q[$];
    int         stamp_q[$];
    int         cyc;
    int         checks;
    int         errors;

    rr_packet_arbiter_4_to_1 #(.INPUT_BIT_LENGTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_last(in_last),
        .in_data_a(in_data_a), .in_data_b(in_data_b),
        .in_data_c(in_data_c), .in_data_d(in_data_d),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
        .out_ready(out_ready),
        .grant_sel(grant_sel), .busy(busy)
    );

    rr_packet_arbiter_4_to_1 #(.INPUT_BIT_LENGTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(4'b0000), .in_last(4'b0000),
        .in_data_a(1'b0), .in_data_b(1'b0),
        .in_data_c(1'b0), .in_data_d(1'b0),
        .in_ready(d1_in_ready),
        .out_valid(d1_out_valid), .out_last(d1_out_last), .out_data(d1_out_data),
        .out_ready(1'b1),
        .grant_sel(d1_grant_sel), .busy(d1_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: act=0x%0h req=0x%0h", name, act, expv);
        end
    endtask

    task automatic push_beat(input int r, input int gap, input logic last, input logic [7:0] d);
        beat_t b;
        b.gap  = gap;
        b.last = last;
        b.data = d;
        rq[r].push_back(b);
        exp_q.push_back({last, d});
    endtask

    function automatic int pending();
        int p;
        p = exp_q.size();
        for (int i = 0; i < 4; i++) p += rq[i].size();
        return p;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (pending() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(name, pending(), 0);
    endtask

    task automatic wait_exp_size(input string name, input int sz);
        int n;
        n = 0;
        while (exp_q.size() != sz && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(name, exp_q.size(), sz);
    endtask

    // Requester models: each presents the head of its beat queue after its
    // gap, and retires it when a handshake is seen before the rising edge.
    initial begin
        logic [3:0] acc;
        logic [3:0] v, l;
        logic [7:0] d [4];
        in_valid  = 4'b0;
        in_last   = 4'b0;
        in_data_a = 8'h00;
        in_data_b = 8'h00;
        in_data_c = 8'h00;
        in_data_d = 8'h00;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            acc = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && rq[i].size() > 0) begin
                    rq[i].delete(0);
                    cnt[i] = 0;
                end
                v[i] = 1'b0;
                l[i] = 1'b0;
                d[i] = 8'h00;
                if (rq[i].size() > 0) begin
                    if (cnt[i] < rq[i][0].gap) cnt[i]++;
                    else v[i] = 1'b1;
                    l[i] = rq[i][0].last;
                    d[i] = rq[i][0].data;
                end
            end
            in_valid  = v;
            in_last   = l;
            in_data_a = d[0];
            in_data_b = d[1];
            in_data_c = d[2];
            in_data_d = d[3];
        end
    end

    // Scoreboard monitor: every accepted output beat is compared to the head
    // of the expected queue.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat: act=0x%0h req=none (unexpected beat)", {out_last, out_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e) begin
                        errors++;
                        $display("FAIL out_beat: act=0x%0h req=0x%0h", {out_last, out_data}, e);
                    end else begin
                        $display("beat data=0x%02h last=%0b cycle=%0d", out_data, out_last, cyc);
                    end
                end
                stamp_q.push_back(cyc);
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst       = 1'b1;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_sel", grant_sel, 0);
        rst = 1'b0;

        // 1: all requesters with single-beat packets, order 0,1,2,3,0
        @(negedge clk);
        stamp_q.delete();
        push_beat(0, 0, 1'b1, 8'h10);
        push_beat(1, 0, 1'b1, 8'h11);
        push_beat(2, 0, 1'b1, 8'h12);
        push_beat(3, 0, 1'b1, 8'h13);
        push_beat(0, 0, 1'b1, 8'h14);
        wait_done("t1_done", 100);
        chk("t1_nbeats", stamp_q.size(), 5);
        for (int i = 1; i < 5 && i < stamp_q.size(); i++)
            chk("t1_spacing", stamp_q[i] - stamp_q[i-1], 2);

        // 2: req 2 multi-beat packet while req 1 waits
        @(negedge clk);
        stamp_q.delete();
        push_beat(2, 0, 1'b0, 8'h0A);
        push_beat(2, 0, 1'b0, 8'h0B);
        push_beat(2, 0, 1'b1, 8'h0C);
        repeat (2) @(negedge clk);
        push_beat(1, 0, 1'b1, 8'h21);
        for (int n = 0; n < 20 && exp_q.size() > 1; n++) begin
            @(negedge clk);
            if (exp_q.size() > 1) chk("t2_in_ready1", in_ready[1], 0);
        end
        wait_done("t2_done", 100);
        chk("t2_nbeats", stamp_q.size(), 4);
        if (stamp_q.size() == 4) begin
            chk("t2_ab_gap", stamp_q[1] - stamp_q[0], 1);
            chk("t2_bc_gap", stamp_q[2] - stamp_q[1], 1);
            chk("t2_c_next_gap", stamp_q[3] - stamp_q[2], 2);
        end

        // 3: backpressure mid-packet
        @(negedge clk);
        push_beat(0, 0, 1'b0, 8'h30);
        push_beat(0, 0, 1'b0, 8'h31);
        push_beat(0, 0, 1'b0, 8'h32);
        push_beat(0, 0, 1'b1, 8'h33);
        wait_exp_size("t3_sync", 3);
        out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t3_frozen_data", out_data, 8'h31);
            chk("t3_frozen_valid", out_valid, 1);
            chk("t3_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_done("t3_done", 100);

        // 4: granted req 3 stalls mid-packet while req 0 waits
        @(negedge clk);
        push_beat(3, 0, 1'b0, 8'h40);
        push_beat(3, 0, 1'b0, 8'h41);
        push_beat(3, 5, 1'b1, 8'h42);
        push_beat(0, 0, 1'b1, 8'h50);
        wait_exp_size("t4_sync", 2);
        repeat (3) begin
            @(negedge clk);
            chk("t4_busy", busy, 1);
            chk("t4_grant_sel", grant_sel, 3);
            chk("t4_in_ready0", in_ready[0], 0);
        end
        wait_done("t4_done", 100);

        // 5: reset mid-packet with a held output beat
        @(negedge clk);
        out_ready = 1'b0;
        push_beat(1, 0, 1'b0, 8'h60);
        push_beat(1, 0, 1'b0, 8'h61);
        push_beat(1, 0, 1'b1, 8'h62);
        repeat (4) @(negedge clk);
        chk("t5_held_valid", out_valid, 1);
        chk("t5_held_data", out_data, 8'h60);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_in_ready", in_ready, 0);
        chk("t5_rst_busy", busy, 0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            rq[i].delete();
            cnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        push_beat(0, 0, 1'b1, 8'h70);
        push_beat(1, 0, 1'b1, 8'h71);
        push_beat(2, 0, 1'b1, 8'h72);
        wait_done("t5_done", 100);

        // 6: idle for 10 cycles on both instances
        repeat (10) begin
            @(negedge clk);
            chk("t6_out_valid", out_valid, 0);
            chk("t6_in_ready", in_ready, 0);
            chk("t6_busy", busy, 0);
            chk("t6_grant_sel", grant_sel, 2);
            chk("t6_w1_out_valid", d1_out_valid, 0);
            chk("t6_w1_in_ready", d1_in_ready, 0);
            chk("t6_w1_busy", d1_busy, 0);
            chk("t6_w1_grant_sel", d1_grant_sel, 0);
            chk("t6_w1_out_word", {d1_out_last, d1_out_data}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
